// File: rtl/mul_axi4s_pkg.sv
// Shared types and helpers for the AXI4-Stream multiplier master and slave wrapper.
package mul_axi4s_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSendA,
    StSendB,
    StWaitRsp
  } mul_state_e;

  // Number of sign bits prepended when an operand is widened onto tdata.
  function automatic int sext_bits(input int data_w, input int n_bits);
    return data_w - n_bits;
  endfunction

endpackage

// File: rtl/nq_multiplier_axi4s_master_if.sv
// Request/response port plus operand and result AXI4-Stream channels of the multiplier master.
interface nq_multiplier_axi4s_master_if #(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int N_BITS_P         = 32
);

  logic                        req_valid;
  logic                        req_ready;
  logic [N_BITS_P-1:0]         req_multiplicand;
  logic [N_BITS_P-1:0]         req_multiplier;
  logic [AXI_ID_WIDTH_P-1:0]   req_id;

  logic                        mul_tvalid;
  logic                        mul_tready;
  logic [AXI_DATA_WIDTH_P-1:0] mul_tdata;
  logic                        mul_tlast;
  logic [AXI_ID_WIDTH_P-1:0]   mul_tid;

  logic                        res_tvalid;
  logic [AXI_DATA_WIDTH_P-1:0] res_tdata;
  logic                        res_tlast;
  logic [AXI_ID_WIDTH_P-1:0]   res_tid;
  logic                        res_tuser;

  logic                        rsp_valid;
  logic [N_BITS_P-1:0]         rsp_product;
  logic                        rsp_overflow;
  logic [AXI_ID_WIDTH_P-1:0]   rsp_id;
  logic                        rsp_error;

  modport master (
    input  req_valid, req_multiplicand, req_multiplier, req_id,
    output req_ready,
    output mul_tvalid, mul_tdata, mul_tlast, mul_tid,
    input  mul_tready,
    input  res_tvalid, res_tdata, res_tlast, res_tid, res_tuser,
    output rsp_valid, rsp_product, rsp_overflow, rsp_id, rsp_error
  );

  modport slave (
    output req_valid, req_multiplicand, req_multiplier, req_id,
    input  req_ready,
    input  mul_tvalid, mul_tdata, mul_tlast, mul_tid,
    output mul_tready,
    output res_tvalid, res_tdata, res_tlast, res_tid, res_tuser,
    input  rsp_valid, rsp_product, rsp_overflow, rsp_id, rsp_error
  );

endinterface

// File: rtl/nq_multiplier_axi4s_master.sv
// Sends two sign-extended operand beats to a stream multiplier and returns its result.
// Optional response timeout enabled by defining MUL_MASTER_TIMEOUT_EN.
module nq_multiplier_axi4s_master
  import mul_axi4s_pkg::*;
#(
  parameter int AXI_DATA_WIDTH_P = -1,
  parameter int AXI_ID_WIDTH_P   = -1,
  parameter int N_BITS_P         = -1,
  parameter int TIMEOUT_CYCLES_P = 1024
) (
  input logic                         clk,
  input logic                         rst,
  nq_multiplier_axi4s_master_if.master bus
);

  localparam int SextBits = sext_bits(AXI_DATA_WIDTH_P, N_BITS_P);

  mul_state_e                  state_q;
  logic                        req_ready_q;
  logic                        mul_tvalid_q;
  logic [AXI_DATA_WIDTH_P-1:0] mul_tdata_q;
  logic                        mul_tlast_q;
  logic [AXI_ID_WIDTH_P-1:0]   mul_tid_q;
  logic [AXI_DATA_WIDTH_P-1:0] b_q;
  logic                        rsp_valid_q;
  logic [N_BITS_P-1:0]         rsp_product_q;
  logic                        rsp_overflow_q;
  logic [AXI_ID_WIDTH_P-1:0]   rsp_id_q;
  logic                        rsp_error_q;

  logic [AXI_DATA_WIDTH_P-1:0] a_ext;
  logic [AXI_DATA_WIDTH_P-1:0] b_ext;

  if (SextBits > 0) begin : g_sext
    assign a_ext = {{SextBits{bus.req_multiplicand[N_BITS_P-1]}}, bus.req_multiplicand};
    assign b_ext = {{SextBits{bus.req_multiplier[N_BITS_P-1]}}, bus.req_multiplier};
  end else begin : g_nosext
    assign a_ext = bus.req_multiplicand;
    assign b_ext = bus.req_multiplier;
  end

`ifdef MUL_MASTER_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES_P + 1);
  logic [TmoW-1:0] tmo_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      req_ready_q    <= 1'b1;
      mul_tvalid_q   <= 1'b0;
      mul_tdata_q    <= '0;
      mul_tlast_q    <= 1'b0;
      mul_tid_q      <= '0;
      b_q            <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_product_q  <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_id_q       <= '0;
      rsp_error_q    <= 1'b0;
`ifdef MUL_MASTER_TIMEOUT_EN
      tmo_q          <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            state_q      <= StSendA;
            req_ready_q  <= 1'b0;
            mul_tvalid_q <= 1'b1;
            mul_tdata_q  <= a_ext;
            mul_tlast_q  <= 1'b0;
            mul_tid_q    <= bus.req_id;
            b_q          <= b_ext;
          end
        end
        StSendA: begin
          if (bus.mul_tready) begin
            state_q     <= StSendB;
            mul_tdata_q <= b_q;
            mul_tlast_q <= 1'b1;
          end
        end
        StSendB: begin
          if (bus.mul_tready) begin
            state_q      <= StWaitRsp;
            mul_tvalid_q <= 1'b0;
            mul_tlast_q  <= 1'b0;
`ifdef MUL_MASTER_TIMEOUT_EN
            tmo_q        <= '0;
`endif
          end
        end
        StWaitRsp: begin
          // A result arriving on the expiry cycle takes priority over the timeout.
          if (bus.res_tvalid) begin
            state_q        <= StIdle;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b1;
            rsp_product_q  <= bus.res_tdata[N_BITS_P-1:0];
            rsp_overflow_q <= bus.res_tuser;
            rsp_id_q       <= mul_tid_q;
            rsp_error_q    <= (bus.res_tid != mul_tid_q) || !bus.res_tlast;
          end
`ifdef MUL_MASTER_TIMEOUT_EN
          else if (tmo_q == TmoW'(TIMEOUT_CYCLES_P - 1)) begin
            state_q        <= StIdle;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b1;
            rsp_product_q  <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_id_q       <= mul_tid_q;
            rsp_error_q    <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.mul_tvalid   = mul_tvalid_q;
  assign bus.mul_tdata    = mul_tdata_q;
  assign bus.mul_tlast    = mul_tlast_q;
  assign bus.mul_tid      = mul_tid_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_product  = rsp_product_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_nq_multiplier_axi4s_master.sv
// Directed and randomized bench for nq_multiplier_axi4s_master with a Q16 stub multiplier slave.
module tb_nq_multiplier_axi4s_master;

  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int NB  = 32;
  localparam int TMO = 16;
  localparam longint QMax = 64'sh0000_0000_7FFF_FFFF;
  localparam longint QMin = -64'sh0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nq_multiplier_axi4s_master_if #(
    .AXI_DATA_WIDTH_P(DW),
    .AXI_ID_WIDTH_P  (IW),
    .N_BITS_P        (NB)
  ) bus ();

  nq_multiplier_axi4s_master #(
    .AXI_DATA_WIDTH_P(DW),
    .AXI_ID_WIDTH_P  (IW),
    .N_BITS_P        (NB),
    .TIMEOUT_CYCLES_P(TMO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total  = 0;
  int passed = 0;
  int n_beats = 0;
  int n_rsp   = 0;
  logic [DW-1:0] beat_data[$];

  // Mid-cycle monitor: what is visible at a falling edge is what the next rising edge samples.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mul_tvalid && bus.mul_tready) begin
        beat_data.push_back(bus.mul_tdata);
        n_beats++;
      end
      if (bus.rsp_valid) n_rsp++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Q16.16 signed product with saturation-free overflow flag.
  task automatic q16_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] p, output logic ovf);
    longint sa, sb, sp;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sp  = (sa * sb) >>> 16;
    p   = sp[31:0];
    ovf = (sp > QMax) || (sp < QMin);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [IW-1:0] id,
                      input int sa, input int sb);
    int k;
    int beats0;
    beats0 = n_beats;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      tick();
      k++;
    end
    check("req_ready_idle", 64'(bus.req_ready), 64'(1));
    bus.mul_tready       = 1'b0;
    bus.req_valid        = 1'b1;
    bus.req_multiplicand = a;
    bus.req_multiplier   = b;
    bus.req_id           = id;
    tick();
    bus.req_valid = 1'b0;
    check("req_ready_busy", 64'(bus.req_ready), 64'(0));
    check("beat_a", 64'({bus.mul_tvalid, bus.mul_tlast, bus.mul_tid, bus.mul_tdata}),
          64'({1'b1, 1'b0, id, a}));
    repeat (sa) begin
      tick();
      check("beat_a_hold", 64'({bus.mul_tvalid, bus.mul_tlast, bus.mul_tid, bus.mul_tdata}),
            64'({1'b1, 1'b0, id, a}));
    end
    bus.mul_tready = 1'b1;
    tick();
    check("beat_b", 64'({bus.mul_tvalid, bus.mul_tlast, bus.mul_tid, bus.mul_tdata}),
          64'({1'b1, 1'b1, id, b}));
    if (sb > 0) begin
      bus.mul_tready = 1'b0;
      repeat (sb) begin
        tick();
        check("beat_b_hold", 64'({bus.mul_tvalid, bus.mul_tlast, bus.mul_tid, bus.mul_tdata}),
              64'({1'b1, 1'b1, id, b}));
      end
      bus.mul_tready = 1'b1;
    end
    tick();
    bus.mul_tready = 1'b0;
    check("tvalid_drop", 64'(bus.mul_tvalid), 64'(0));
    check("handshakes", 64'(n_beats - beats0), 64'(2));
  endtask

  task automatic respond(input logic [31:0] a, input logic [31:0] b, input logic [IW-1:0] id,
                         input logic [IW-1:0] rtid, input logic rlast, input logic force_ovf);
    logic [31:0] p_exp, p_stub, da, db;
    logic o_exp, o_stub, e_exp;
    int rsp0;
    rsp0 = n_rsp;
    da = 32'h0;
    db = 32'h0;
    if (beat_data.size() >= 2) begin
      da = beat_data[0];
      db = beat_data[1];
    end
    beat_data.delete();
    q16_mul(da, db, p_stub, o_stub);
    q16_mul(a, b, p_exp, o_exp);
    e_exp = (rtid != id) || !rlast;
    bus.res_tvalid = 1'b1;
    bus.res_tdata  = p_stub;
    bus.res_tid    = rtid;
    bus.res_tlast  = rlast;
    bus.res_tuser  = o_stub | force_ovf;
    tick();
    bus.res_tvalid = 1'b0;
    check("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check("rsp_product", 64'(bus.rsp_product), 64'(p_exp));
    check("rsp_overflow", 64'(bus.rsp_overflow), 64'(o_exp | force_ovf));
    check("rsp_id", 64'(bus.rsp_id), 64'(id));
    check("rsp_error", 64'(bus.rsp_error), 64'(e_exp));
    check("req_ready_back", 64'(bus.req_ready), 64'(1));
    tick();
    check("rsp_one_cycle", 64'(bus.rsp_valid), 64'(0));
    check("rsp_hold", 64'({bus.rsp_product, bus.rsp_id, bus.rsp_error}),
          64'({p_exp, id, e_exp}));
    check("rsp_count", 64'(n_rsp - rsp0), 64'(1));
  endtask

  initial begin
    logic [31:0] ra, rb, held;
    logic [IW-1:0] rid;
    int k;
    int rsp0;

    bus.req_valid        = 1'b0;
    bus.req_multiplicand = '0;
    bus.req_multiplier   = '0;
    bus.req_id           = '0;
    bus.mul_tready       = 1'b0;
    bus.res_tvalid       = 1'b0;
    bus.res_tdata        = '0;
    bus.res_tlast        = 1'b0;
    bus.res_tid          = '0;
    bus.res_tuser        = 1'b0;

    repeat (3) tick();
    check("reset_ready", 64'(bus.req_ready), 64'(1));
    check("reset_mul", 64'({bus.mul_tvalid, bus.mul_tlast, bus.mul_tid, bus.mul_tdata}), 64'(0));
    check("reset_rsp", 64'({bus.rsp_valid, bus.rsp_product, bus.rsp_overflow, bus.rsp_id,
                            bus.rsp_error}), 64'(0));
    rst = 1'b0;
    tick();

    // Reference transaction: 2.0 * 3.0 in Q16.
    send(32'h0002_0000, 32'h0003_0000, 4'd3, 0, 0);
    respond(32'h0002_0000, 32'h0003_0000, 4'd3, 4'd3, 1'b1, 1'b0);
    check("ref_product", 64'(bus.rsp_product), 64'(32'h0006_0000));

    send(32'h0001_8000, 32'hFFFE_0000, 4'd7, 5, 5);
    respond(32'h0001_8000, 32'hFFFE_0000, 4'd7, 4'd7, 1'b1, 1'b0);

    send(32'h0000_4000, 32'h0004_0000, 4'd3, 1, 2);
    respond(32'h0000_4000, 32'h0004_0000, 4'd3, 4'd5, 1'b1, 1'b0);

    send(32'h0003_0000, 32'h0003_0000, 4'd9, 0, 1);
    respond(32'h0003_0000, 32'h0003_0000, 4'd9, 4'd9, 1'b0, 1'b0);

    send(32'h0001_0000, 32'h0001_0000, 4'd1, 0, 0);
    respond(32'h0001_0000, 32'h0001_0000, 4'd1, 4'd1, 1'b1, 1'b1);

    // Stray result while idle must be ignored.
    rsp0 = n_rsp;
    held = bus.rsp_product;
    bus.res_tvalid = 1'b1;
    bus.res_tdata  = 32'hDEAD_BEEF;
    bus.res_tid    = 4'd2;
    bus.res_tlast  = 1'b1;
    tick();
    bus.res_tvalid = 1'b0;
    repeat (2) tick();
    check("stray_no_rsp", 64'(n_rsp - rsp0), 64'(0));
    check("stray_hold", 64'({bus.rsp_product, bus.rsp_overflow}), 64'({held, 1'b1}));
    check("stray_ready", 64'(bus.req_ready), 64'(1));

    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rid = IW'($urandom_range(0, 15));
      send(ra, rb, rid, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      respond(ra, rb, rid, rid, 1'b1, 1'b0);
    end

    send(32'h0005_0000, 32'h0002_0000, 4'd6, 0, 0);
    rsp0 = n_rsp;
`ifdef MUL_MASTER_TIMEOUT_EN
    k = 0;
    while (!bus.rsp_valid && k < 40) begin
      tick();
      k++;
    end
    check("tmo_latency", 64'(k), 64'(TMO));
    check("tmo_rsp", 64'({bus.rsp_valid, bus.rsp_product, bus.rsp_overflow, bus.rsp_id,
                          bus.rsp_error}), 64'({1'b1, 32'h0, 1'b0, 4'd6, 1'b1}));
    tick();
    check("tmo_one_cycle", 64'(bus.rsp_valid), 64'(0));
    beat_data.delete();
`else
    k = 0;
    repeat (40) begin
      tick();
      if (bus.rsp_valid) k++;
    end
    check("wait_forever", 64'(k), 64'(0));
    check("wait_not_ready", 64'(bus.req_ready), 64'(0));
    respond(32'h0005_0000, 32'h0002_0000, 4'd6, 4'd6, 1'b1, 1'b0);
`endif

    // Reset while the second beat is pending.
    bus.req_valid        = 1'b1;
    bus.req_multiplicand = 32'h0002_0000;
    bus.req_multiplier   = 32'h0002_0000;
    bus.req_id           = 4'd4;
    tick();
    bus.req_valid  = 1'b0;
    bus.mul_tready = 1'b1;
    tick();
    bus.mul_tready = 1'b0;
    check("pre_rst_sendb", 64'({bus.mul_tvalid, bus.mul_tlast}), 64'({1'b1, 1'b1}));
    rsp0 = n_rsp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat_data.delete();
    check("rst_tvalid", 64'(bus.mul_tvalid), 64'(0));
    check("rst_ready", 64'(bus.req_ready), 64'(1));
    bus.res_tvalid = 1'b1;
    bus.res_tdata  = 32'h0004_0000;
    bus.res_tid    = 4'd4;
    bus.res_tlast  = 1'b1;
    tick();
    bus.res_tvalid = 1'b0;
    repeat (3) tick();
    check("rst_no_rsp", 64'(n_rsp - rsp0), 64'(0));
    check("rst_rsp_cleared", 64'({bus.rsp_product, bus.rsp_id}), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
